// File: rtl/timer_setter.sv
// timer_setter: front-panel entry controller for the hour/min/sec timer.
// Turns button presses into a bounded preset, then runs the write/start
// handshake into the timer and waits out the run on buzy_n.
module timer_setter #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned HOUR_MAX   = 99,
   parameter int unsigned REPEAT_DLY = 4,
   parameter int unsigned REPEAT_PER = 2,
   parameter int unsigned START_TO   = 8
) (
   input  logic             clk,
   input  logic             cut_n,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic             btn_dec,
   input  logic             btn_clr,
   input  logic             btn_go,
   input  logic             sw_up,
   input  logic             buzy_n,
   output logic [WIDTH-1:0] insec,
   output logic [WIDTH-1:0] inmin,
   output logic [WIDTH-1:0] inhour,
   output logic             up,
   output logic             write,
   output logic             start,
   output logic [1:0]       sel,
   output logic             running,
   output logic             err
);

   localparam int unsigned RCW = $clog2(REPEAT_DLY + 1);
   localparam int unsigned TCW = $clog2(START_TO + 1);
   localparam logic [WIDTH-1:0] MS_MAX = WIDTH'(59);
   localparam logic [WIDTH-1:0] HR_MAX = WIDTH'(HOUR_MAX);

   typedef enum logic [1:0] {S_EDIT, S_WRITE, S_START, S_RUN} state_t;

   state_t           state;
   logic [4:0]       btn_prev;     // {go, clr, mode, inc, dec}
   logic [RCW-1:0]   inc_cnt;
   logic [RCW-1:0]   dec_cnt;
   logic [TCW-1:0]   to_cnt;
   logic             seen_low;

   logic             go_edge_c, clr_edge_c, mode_edge_c, inc_edge_c, dec_edge_c;
   logic             both_c, inc_step_c, dec_step_c, all_zero_c;
   logic [RCW-1:0]   inc_nxt_c, dec_nxt_c;
   logic [WIDTH-1:0] sel_max_c;

   function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] mx);
      return (v >= mx) ? '0 : v + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] mx);
      return (v == '0 || v > mx) ? mx : v - WIDTH'(1);
   endfunction

   // Edge detection, auto-repeat strobes and launch qualification
   always_comb begin
      go_edge_c   = btn_go   & ~btn_prev[4];
      clr_edge_c  = btn_clr  & ~btn_prev[3];
      mode_edge_c = btn_mode & ~btn_prev[2];
      inc_edge_c  = btn_inc  & ~btn_prev[1];
      dec_edge_c  = btn_dec  & ~btn_prev[0];
      both_c      = btn_inc & btn_dec;
      inc_nxt_c   = inc_cnt + RCW'(1);
      dec_nxt_c   = dec_cnt + RCW'(1);
      inc_step_c  = ~both_c & (inc_edge_c |
                    (btn_inc & btn_prev[1] & (inc_nxt_c == RCW'(REPEAT_DLY))));
      dec_step_c  = ~both_c & (dec_edge_c |
                    (btn_dec & btn_prev[0] & (dec_nxt_c == RCW'(REPEAT_DLY))));
      all_zero_c  = (insec == '0) && (inmin == '0) && (inhour == '0);
      sel_max_c   = (sel == 2'd2) ? HR_MAX : MS_MAX;
   end

   // Main controller: editing, handshake sequencing and run supervision
   always_ff @(posedge clk or posedge cut_n) begin
      if (cut_n) begin
         state    <= S_EDIT;
         btn_prev <= '0;
         inc_cnt  <= '0;
         dec_cnt  <= '0;
         to_cnt   <= '0;
         seen_low <= 1'b0;
         insec    <= '0;
         inmin    <= '0;
         inhour   <= '0;
         up       <= 1'b0;
         write    <= 1'b0;
         start    <= 1'b0;
         sel      <= 2'd0;
         running  <= 1'b0;
         err      <= 1'b0;
      end else begin
         btn_prev <= {btn_go, btn_clr, btn_mode, btn_inc, btn_dec};
         write    <= 1'b0;
         start    <= 1'b0;
         err      <= 1'b0;

         // Repeat counters: restart on edge, reload by one period after each repeat step
         if (state != S_EDIT || !btn_inc || both_c || inc_edge_c) inc_cnt <= '0;
         else if (inc_nxt_c == RCW'(REPEAT_DLY)) inc_cnt <= RCW'(REPEAT_DLY - REPEAT_PER);
         else inc_cnt <= inc_nxt_c;

         if (state != S_EDIT || !btn_dec || both_c || dec_edge_c) dec_cnt <= '0;
         else if (dec_nxt_c == RCW'(REPEAT_DLY)) dec_cnt <= RCW'(REPEAT_DLY - REPEAT_PER);
         else dec_cnt <= dec_nxt_c;

         case (state)
            S_EDIT: begin
               up <= sw_up;
               if (go_edge_c) begin
                  if (!buzy_n || (!sw_up && all_zero_c)) begin
                     err <= 1'b1;
                  end else begin
                     state   <= S_WRITE;
                     write   <= 1'b1;
                     running <= 1'b1;
                  end
               end else if (clr_edge_c) begin
                  insec  <= '0;
                  inmin  <= '0;
                  inhour <= '0;
               end else if (mode_edge_c) begin
                  sel <= (sel >= 2'd2) ? 2'd0 : sel + 2'd1;
               end else if (inc_step_c || dec_step_c) begin
                  case (sel)
                     2'd0:    insec  <= inc_step_c ? step_up(insec,  sel_max_c) : step_dn(insec,  sel_max_c);
                     2'd1:    inmin  <= inc_step_c ? step_up(inmin,  sel_max_c) : step_dn(inmin,  sel_max_c);
                     2'd2:    inhour <= inc_step_c ? step_up(inhour, sel_max_c) : step_dn(inhour, sel_max_c);
                     default: ;
                  endcase
               end
            end
            S_WRITE: begin
               if (!buzy_n) begin
                  state   <= S_EDIT;
                  err     <= 1'b1;
                  running <= 1'b0;
               end else begin
                  state <= S_START;
                  start <= 1'b1;
               end
            end
            S_START: begin
               state    <= S_RUN;
               to_cnt   <= '0;
               seen_low <= 1'b0;
            end
            S_RUN: begin
               if (!buzy_n) begin
                  seen_low <= 1'b1;
               end else if (seen_low) begin
                  state   <= S_EDIT;
                  running <= 1'b0;
               end else if (to_cnt == TCW'(START_TO - 1)) begin
                  state   <= S_EDIT;
                  err     <= 1'b1;
                  running <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TCW'(1);
               end
            end
            default: begin
               state   <= S_EDIT;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/timer_setter.md
Name: timer_setter

Overview:
- Front-panel entry controller directly upstream of the hour/min/sec timer.
- Turns push-button presses into a bounded hour/min/sec preset and a count direction.
- Runs the write-then-start handshake into the timer.
- Waits out the run using the timer's buzy_n, then returns to editing.

Parameters:
WIDTH, 16, width of the insec/inmin/inhour buses (matches timer `width)
HOUR_MAX, 99, largest settable hour value; must be < 2^WIDTH
REPEAT_DLY, 4, cycles btn_inc/btn_dec must stay held before auto-repeat begins
REPEAT_PER, 2, cycles between auto-repeat steps while held
START_TO, 8, cycles to wait in RUN for buzy_n to fall before giving up

Ports:
clk  in  1  timer clock; all logic on rising edge
cut_n  in  1  asynchronous reset, active-high (name kept for codebase consistency)
btn_mode  in  1  level; rising edge advances the edited field
btn_inc  in  1  level; rising edge (plus auto-repeat) increments the selected field
btn_dec  in  1  level; rising edge (plus auto-repeat) decrements the selected field
btn_clr  in  1  level; rising edge zeroes all three fields
btn_go  in  1  level; rising edge requests launch
sw_up  in  1  direction switch: 1 = count up, 0 = count down
buzy_n  in  1  from timer; low while the timer is running
insec  out  WIDTH  preset seconds, 0..59, to timer
inmin  out  WIDTH  preset minutes, 0..59, to timer
inhour  out  WIDTH  preset hours, 0..HOUR_MAX, to timer
up  out  1  registered direction, to timer
write  out  1  one-cycle pulse, to timer
start  out  1  one-cycle pulse, to timer
sel  out  2  edited field: 0 = sec, 1 = min, 2 = hour
running  out  1  high in WRITE/START/RUN
err  out  1  one-cycle pulse on a rejected go or on RUN timeout

Behaviour:
- Reset state (async, cut_n=1): insec/inmin/inhour = 0, up = 0, write = start = err = 0, sel = 0, running = 0, state = EDIT, repeat counters cleared.
- Button edge detection:
  - Each btn_* is registered once; the edge is current & ~prev.
  - Prev registers reset to 0, so a button held through reset release produces one edge on the first clock.
- States: EDIT, WRITE, START, RUN.
- EDIT:
  - up <= sw_up every cycle.
  - mode edge: sel 0 -> 1 -> 2 -> 0.
  - inc step on sel 0/1: 59 wraps to 0, else +1. On sel 2: HOUR_MAX wraps to 0.
  - dec step on sel 0/1: 0 wraps to 59, else -1. On sel 2: 0 wraps to HOUR_MAX.
  - inc and dec active in the same cycle: no change; both repeat counters clear.
  - Auto-repeat: after an edge, a button continuously held for REPEAT_DLY more cycles steps again, then every REPEAT_PER cycles. Releasing clears its counter.
  - clr edge: all fields 0. Takes priority over an inc/dec in the same cycle. sel unchanged.
  - Priority when several edges coincide: go > clr > mode > inc/dec.
  - go edge with buzy_n=1 and not (sw_up=0 and all fields 0): go to WRITE.
  - go edge with sw_up=0 and all fields 0: err=1 for one cycle, stay in EDIT.
  - go edge with buzy_n=0: err=1 for one cycle, stay in EDIT.
- WRITE (1 cycle):
  - write=1; up and fields frozen; next state START.
  - If buzy_n=0 here, abort to EDIT with err=1 and start not issued.
- START (1 cycle): start=1; next state RUN; clear timeout counter.
- RUN:
  - All buttons ignored; outputs frozen.
  - Once buzy_n has been seen 0, the next buzy_n=1 (alarm or cut on the timer) returns to EDIT. Fields keep their preset for reuse.
  - If buzy_n never falls within START_TO cycles of entering RUN: err=1, back to EDIT.
- write and start are never high together, and neither is high outside WRITE/START.
- Latency: go edge registered at edge N -> write high in cycle N+1, start in N+2.
- cut_n mid-operation: immediate return to reset values in any state; pulses end asynchronously.

Test Plan:
- Reset, sel=0, press inc 3 times, mode, dec once -> insec=3, inmin=59, sel=1, write/start stay 0.
- sel=2, inhour=HOUR_MAX=99, inc edge -> inhour=0. Dec edge -> 99.
- Hold btn_inc 12 cycles on sel=0 from 0, REPEAT_DLY=4, REPEAT_PER=2 -> steps at edge cycle +0, +4, +6, +8, +10; insec=5.
- sw_up=0, fields 0:1:0, buzy_n=1, go -> write one cycle with inmin=1, up=0; start next cycle; running=1.
- From that run, drive buzy_n low 3 cycles then high -> back to EDIT, running=0, inmin still 1.
- sw_up=0, all fields 0, go -> err pulse, no write.
- Start a run, hold buzy_n=1 -> err after START_TO=8 cycles in RUN, state EDIT.
- cut_n asserted during START -> start deasserts immediately, fields 0, sel 0.
